aesl_deadlock_idx0_monitor: RTL and testbench
=============================================

# aesl_deadlock_idx0_monitor

Deadlock detector for the top-level sequential region (index 0) of an HLS kernel in simulation. It combines per-instance AXI-Stream stall flags, sub-instance idle flags and child-monitor block flags into one filtered `block` indication. The kernel monitor top uses `block` to trigger the deadlock diagnosis report.

## Interface
Parameters:
- `AXIS_N`, 2: number of monitored AXI-Stream block flags; one per sub-instance.
- `INST_N`, 3: number of idle flags. Bit 0 is the region itself; bits 1..`INST_N-1` are sub-instances; `INST_N = AXIS_N+1`.
- `BLK_N`, 1: number of child-monitor block flags.
- `BLOCK_THRESH`, 4: consecutive raw-block cycles required before `block` asserts; ≥1.

Ports:
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `axis_block_sigs`, in, `AXIS_N`: bit k=1 means sub-instance k+1 is stalled on its AXIS port (outer side not ready).
- `inst_idle_sigs`, in, `INST_N`: bit i=1 means instance i is idle.
- `inst_block_sigs`, in, `BLK_N`: bit j=1 means nested monitor j reports a block.
- `block`, out, 1: registered deadlock indication.

## Operation
- `stall[k] = axis_block_sigs[k] & ~inst_idle_sigs[k+1]`. Stall flags from idle sub-instances are ignored.
- `raw_block = ~inst_idle_sigs[0] & ( |stall | |inst_block_sigs )`. When the region itself is idle, nothing is blocked.
- Persistence counter `cnt`, width `$clog2(BLOCK_THRESH)+1`, saturating at `BLOCK_THRESH`:
  - `raw_block=1`: `cnt <= min(cnt+1, BLOCK_THRESH)`.
  - `raw_block=0`: `cnt <= 0`.
- `block <= raw_block & (cnt+1 >= BLOCK_THRESH)`. The comparison is computed one bit wider, so it cannot wrap.
- A single-cycle `raw_block` drop clears the counter, and the threshold restarts from zero.
- Inputs are treated as already synchronous to `clock`; no synchronizers.
- X/Z on any input is treated as 0 for `raw_block`. Simulation-only `$warning` once per reset epoch.

## Timing
- Reset (async assert, sync deassert internally sampled): `cnt=0`, `block=0` immediately on `reset` rise.
- Latency: `block` rises on the `BLOCK_THRESH`-th consecutive rising edge at which `raw_block=1` is sampled.
  - `BLOCK_THRESH=1`: `block` is `raw_block` delayed one cycle.
- Deassert: `block` falls on the first edge sampling `raw_block=0` (one-cycle latency), unless sticky (see Configuration).
- Reset mid-count or while `block=1`: both cleared asynchronously. Counting restarts on the first edge after `reset` falls.
- Simultaneous idle rise and stall on the same instance: idle wins, and the stall is masked that cycle.
- Changing inputs between edges has no effect; only edge-sampled values count.

## Configuration
- `DEADLOCK_MONITOR_STICKY_EN`:
  - Defined: once `block` asserts it stays 1 until `reset`, regardless of `raw_block`; `cnt` freezes at `BLOCK_THRESH`.
  - Undefined: `block` follows the filtered `raw_block` as described above.

## Test plan
- Reset: `reset=1` with `axis_block_sigs=2'b11`, `inst_idle_sigs=3'b000` → `block=0` throughout. Asserting `reset` while `block=1` drops it without a clock edge.
- Persistence: `BLOCK_THRESH=4`, `inst_idle_sigs=3'b000`, `axis_block_sigs=2'b01` held → `block` 0 for edges 1–3, 1 from edge 4. Setting `axis_block_sigs=0` → `block=0` after next edge (non-sticky).
- Idle masking: `axis_block_sigs=2'b10`, `inst_idle_sigs=3'b100` for 10 cycles → `block` stays 0. Setting `inst_idle_sigs=3'b000` → `block=1` after 4 edges.
- Region idle: `inst_idle_sigs[0]=1`, `inst_block_sigs=1`, `axis_block_sigs=2'b11` → `block=0`.
- Glitch restart: `raw_block` high 3 cycles, low 1, high 4 → `block` asserts only on the 4th edge of the second run.
- Sticky build: same as persistence, then `axis_block_sigs=0` → `block` remains 1 until `reset`. Without the macro, it falls after one edge.

Source files
------------

// File: rtl/aesl_deadlock_idx0_monitor.sv
// Deadlock monitor for sequential region 0: merges stall, idle and child-block flags into a persistence-filtered block.
// Optional build macro DEADLOCK_MONITOR_STICKY_EN latches block until reset.
module aesl_deadlock_idx0_monitor #(
    parameter int AXIS_N       = 2,
    parameter int INST_N       = 3,
    parameter int BLK_N        = 1,
    parameter int BLOCK_THRESH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [AXIS_N-1:0] axis_block_sigs,
    input  logic [INST_N-1:0] inst_idle_sigs,
    input  logic [BLK_N-1:0]  inst_block_sigs,
    output logic              block
);

    localparam int CNT_W = $clog2(BLOCK_THRESH) + 1;
    localparam logic [CNT_W-1:0] THRESH_C    = CNT_W'(BLOCK_THRESH);
    localparam logic [CNT_W:0]   THRESH_WIDE = (CNT_W + 1)'(BLOCK_THRESH);

    logic [AXIS_N-1:0] axis_clean;
    logic [INST_N-1:0] idle_clean;
    logic [BLK_N-1:0]  blk_clean;
    logic [AXIS_N-1:0] stall;
    logic              raw_block;

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W:0]   cnt_inc;
    logic             thresh_hit;
    logic             block_reg, block_next;

    // Only a definite 1 counts; unknown input bits fall back to 0.
    genvar gi;
    generate
        for (gi = 0; gi < AXIS_N; gi++) begin : g_axis
            assign axis_clean[gi] = (axis_block_sigs[gi] === 1'b1);
            assign stall[gi]      = axis_clean[gi] & ~idle_clean[gi+1];
        end
        for (gi = 0; gi < INST_N; gi++) begin : g_idle
            assign idle_clean[gi] = (inst_idle_sigs[gi] === 1'b1);
        end
        for (gi = 0; gi < BLK_N; gi++) begin : g_blk
            assign blk_clean[gi] = (inst_block_sigs[gi] === 1'b1);
        end
    endgenerate

    assign raw_block  = ~idle_clean[0] & ((|stall) | (|blk_clean));
    assign cnt_inc    = {1'b0, cnt_reg} + 1'b1;
    assign thresh_hit = (cnt_inc >= THRESH_WIDE);

    always_comb begin
        cnt_next   = '0;
        block_next = 1'b0;
        if (raw_block) begin
            cnt_next   = thresh_hit ? THRESH_C : cnt_inc[CNT_W-1:0];
            block_next = thresh_hit;
        end
`ifdef DEADLOCK_MONITOR_STICKY_EN
        if (block_reg) begin
            cnt_next   = THRESH_C;
            block_next = 1'b1;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_reg   <= '0;
            block_reg <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            block_reg <= block_next;
        end
    end

    assign block = block_reg;

`ifndef SYNTHESIS
    logic warned_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            warned_reg <= 1'b0;
        end else if (!warned_reg &&
                     $isunknown({axis_block_sigs, inst_idle_sigs, inst_block_sigs})) begin
            $warning("aesl_deadlock_idx0_monitor: X/Z on monitor inputs treated as 0");
            warned_reg <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_aesl_deadlock_idx0_monitor.sv
// Self-checking bench for aesl_deadlock_idx0_monitor: vector table, hand-written corner sequences, random run vs. model.
module tb_aesl_deadlock_idx0_monitor;

    localparam int THRESH = 4;
`ifdef DEADLOCK_MONITOR_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] axis_block_sigs = '0;
    logic [2:0] inst_idle_sigs = '0;
    logic [0:0] inst_block_sigs = '0;
    logic       block;

    int n_checks = 0;
    int n_fail   = 0;

    aesl_deadlock_idx0_monitor #(
        .AXIS_N(2), .INST_N(3), .BLK_N(1), .BLOCK_THRESH(THRESH)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .axis_block_sigs (axis_block_sigs),
        .inst_idle_sigs  (inst_idle_sigs),
        .inst_block_sigs (inst_block_sigs),
        .block           (block)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit       rst;
        bit [1:0] axis;
        bit [2:0] idle;
        bit       blk;
        bit       exp;
    } vec_t;

    vec_t vecs[$];

    // Model: length of the current run of raw-block edges plus a sticky latch.
    int run_len = 0;
    bit model_block = 1'b0;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: block=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit raw_of(input bit [1:0] axis, input bit [2:0] idle, input bit blk);
        bit any_stall = 1'b0;
        for (int k = 0; k < 2; k++)
            if (axis[k] && !idle[k+1]) any_stall = 1'b1;
        return !idle[0] && (any_stall || blk);
    endfunction

    function automatic void model_edge(input bit raw);
        run_len = raw ? run_len + 1 : 0;
        model_block = (raw && run_len >= THRESH) || (STICKY && model_block);
    endfunction

    task automatic add(input bit r, input bit [1:0] a, input bit [2:0] i, input bit b,
                       input bit e, input int n);
        vec_t v;
        for (int c = 0; c < n; c++) begin
            v.rst = r && (c == 0); v.axis = a; v.idle = i; v.blk = b; v.exp = e;
            vecs.push_back(v);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        check("reset_async", block, 1'b0);
        reset = 1'b0;
        run_len = 0;
        model_block = 1'b0;
    endtask

    task automatic drive(input bit [1:0] a, input bit [2:0] i, input bit b);
        axis_block_sigs = a; inst_idle_sigs = i; inst_block_sigs = b;
    endtask

    initial begin
        // Reset held with stalls present: block must stay low.
        drive(2'b11, 3'b000, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            check("reset_hold", block, 1'b0);
        end
        @(negedge clock);
        reset = 1'b0;

        // Region idle, idle masking, unmask latency, drop.
        add(0, 2'b11, 3'b001, 1, 0, 3);
        add(0, 2'b10, 3'b100, 0, 0, 10);
        add(0, 2'b10, 3'b000, 0, 0, 3);
        add(0, 2'b10, 3'b000, 0, 1, 1);
        add(0, 2'b00, 3'b000, 0, STICKY, 1);
        // Glitch restart: 3 high, 1 low, 4 high, with mixed raw sources.
        add(1, 2'b01, 3'b000, 0, 0, 1);
        add(0, 2'b00, 3'b000, 1, 0, 1);
        add(0, 2'b11, 3'b110, 1, 0, 1);
        add(0, 2'b11, 3'b110, 0, 0, 1);
        add(0, 2'b10, 3'b000, 0, 0, 3);
        add(0, 2'b10, 3'b010, 1, 1, 1);
        add(0, 2'b00, 3'b000, 0, STICKY, 1);

        foreach (vecs[n]) begin
            @(negedge clock);
            if (vecs[n].rst) pulse_reset();
            drive(vecs[n].axis, vecs[n].idle, vecs[n].blk);
            @(posedge clock); #1;
            check($sformatf("vec%0d", n), block, vecs[n].exp);
        end

        // Persistence: held stall, edges 1-3 low, 4 high, then drop.
        @(negedge clock);
        pulse_reset();
        drive(2'b01, 3'b000, 1'b0);
        for (int e = 1; e <= 6; e++) begin
            @(posedge clock); #1;
            check($sformatf("persist_edge%0d", e), block, e >= THRESH);
        end
        @(negedge clock);
        drive(2'b00, 3'b000, 1'b0);
        for (int e = 1; e <= 3; e++) begin
            @(posedge clock); #1;
            check($sformatf("drop_edge%0d", e), block, STICKY);
        end

        // Async reset while block is high, between edges.
        @(negedge clock);
        drive(2'b01, 3'b000, 1'b0);
        repeat (THRESH) @(posedge clock);
        #1;
        check("pre_async_high", block, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("async_clear", block, 1'b0);
        @(posedge clock); #1;
        check("async_hold", block, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        drive(2'b01, 3'b000, 1'b0);
        for (int e = 1; e <= THRESH; e++) begin
            @(posedge clock); #1;
            check($sformatf("restart_edge%0d", e), block, e >= THRESH);
        end

        // Random run against the model.
        @(negedge clock);
        pulse_reset();
        for (int c = 0; c < 600; c++) begin
            bit [1:0] a;
            bit [2:0] i;
            bit       b;
            @(negedge clock);
            if ($urandom_range(0, 59) == 0) pulse_reset();
            a    = 2'($urandom);
            i[0] = ($urandom_range(0, 9) == 0);
            i[1] = ($urandom_range(0, 3) == 0);
            i[2] = ($urandom_range(0, 3) == 0);
            b    = ($urandom_range(0, 5) == 0);
            drive(a, i, b);
            #2;
            // Mid-cycle wiggle that must be invisible if reverted before the edge.
            drive(~a, ~i, ~b);
            #1;
            drive(a, i, b);
            @(posedge clock);
            model_edge(raw_of(a, i, b));
            #1;
            check($sformatf("rand%0d", c), block, model_block);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
